alu_rr_arbiter: RTL

//  Shares one 16-bit ripple ALU (instance of alu) between two requesters (0 and 1).

---
 rtl/alu_rr_arbiter_if.sv | 38 +++
 rtl/alu_rr_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter_if.sv
// Request/grant and response bundle between two ALU clients, the shared-ALU arbiter and the result consumer.
// ALU_ARB_ZERO_FLAG_EN adds the rsp_zero response flag.
interface alu_rr_arbiter_if;
    logic        req0;
    logic [1:0]  op0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        gnt0;
    logic        req1;
    logic [1:0]  op1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        gnt1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_cout;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic        rsp_zero;
`endif

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, rsp_ready,
        output gnt0, gnt1, rsp_valid, rsp_id, rsp_data, rsp_cout
`ifdef ALU_ARB_ZERO_FLAG_EN
        , output rsp_zero
`endif
    );

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, rsp_ready,
        input  gnt0, gnt1, rsp_valid, rsp_id, rsp_data, rsp_cout
`ifdef ALU_ARB_ZERO_FLAG_EN
        , input rsp_zero
`endif
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one 16-bit ripple ALU between two requesters, with a registered valid/ready result.
// Optional rsp_zero result flag enabled by defining ALU_ARB_ZERO_FLAG_EN.
module alu (
    input  logic [1:0]  op,
    input  logic [15:0] i0,
    input  logic [15:0] i1,
    output logic [15:0] o,
    output logic        cout
);
    logic        sub;
    logic [16:0] c;
    logic [15:0] x;
    logic [15:0] s;

    // SUB computes i1 - i0 as ~i0 + i1 + 1 on the same ripple chain
    always_comb begin
        sub  = (op == 2'b11);
        c    = '0;
        x    = '0;
        s    = '0;
        c[0] = sub;
        for (int i = 0; i < 16; i++) begin
            x[i]   = i0[i] ^ sub;
            s[i]   = x[i] ^ i1[i] ^ c[i];
            c[i+1] = (x[i] & i1[i]) | (c[i] & (x[i] ^ i1[i]));
        end
        case (op)
            2'b00:   o = i0 & i1;
            2'b01:   o = i0 | i1;
            default: o = s;
        endcase
        cout = c[16];
    end
endmodule

// state | meaning
// IDLE  | waiting for a request; grant is combinational, operands latched on the grant edge
// EXEC  | ALU runs on latched operands; result registered at end of cycle
// RESP  | result presented until rsp_ready; priority then passes to the other requester
module alu_rr_arbiter #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_rr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        id_q, id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_cout_q, rsp_cout_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        gnt0_c, gnt1_c;
    logic [15:0] alu_o;
    logic        alu_cout;

    alu u_alu (
        .op   (op_q),
        .i0   (a_q),
        .i1   (b_q),
        .o    (alu_o),
        .cout (alu_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prio_q      <= PRIO_INIT;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_zero_d  = rsp_zero_q;
        gnt0_c      = 1'b0;
        gnt1_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 && (!bus.req1 || !prio_q)) begin
                    gnt0_c  = 1'b1;
                    op_d    = bus.op0;
                    a_d     = bus.a0;
                    b_d     = bus.b0;
                    id_d    = 1'b0;
                    state_d = ST_EXEC;
                end else if (bus.req1) begin
                    gnt1_c  = 1'b1;
                    op_d    = bus.op1;
                    a_d     = bus.a1;
                    b_d     = bus.b1;
                    id_d    = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_o;
                rsp_cout_d  = alu_cout;
                rsp_zero_d  = (alu_o == 16'h0000);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    prio_d      = ~rsp_id_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // grants are masked while reset is asserted so no pulse escapes with reqs held high
    assign bus.gnt0      = gnt0_c & rst_n;
    assign bus.gnt1      = gnt1_c & rst_n;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_cout  = rsp_cout_q;
`ifdef ALU_ARB_ZERO_FLAG_EN
    assign bus.rsp_zero  = rsp_zero_q;
`endif
endmodule
